// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception/interrupt control stage: exception codes,
// CP0 register addresses, MEM flag positions and the FSM encoding.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_NONE     = 32'h0000_0000;
    localparam logic [31:0] EXC_INT      = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID  = 32'h0000_000a;
    localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int unsigned BIT_SYSCALL  = 8;
    localparam int unsigned BIT_INVALID  = 9;
    localparam int unsigned BIT_TRAP     = 10;
    localparam int unsigned BIT_OVERFLOW = 11;
    localparam int unsigned BIT_ERET     = 12;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StDrain
    } state_t;

    // Software can only write IP1:IP0, IV and WP in Cause; the rest is hardware-owned.
    function automatic logic [31:0] merge_cause(input logic [31:0] cause, input logic [31:0] data);
        logic [31:0] merged;
        merged        = cause;
        merged[9:8]   = data[9:8];
        merged[22]    = data[22];
        merged[23]    = data[23];
        return merged;
    endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Multi-flop synchroniser for asynchronous interrupt lines; output lags input
// by STAGES clock cycles.
module int_sync #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt decision stage beside MEM: picks the highest-priority
// exception or ERET, flushes the pipeline and issues the CP0 entry/return update.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_raw_i,
    output logic [5:0]  int_sync_o,
    input  logic        stall_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        cp0_exc_we_o,
    output logic [31:0] cp0_epc_o,
    output logic [4:0]  cp0_exccode_o,
    output logic        cp0_bd_o,
    output logic        cp0_epc_we_o,
    output logic        cp0_exl_set_o,
    output logic        cp0_exl_clr_o,
    output logic        busy_o
);

    state_t      state;
    logic [31:0] status_fwd;
    logic [31:0] cause_fwd;
    logic [31:0] epc_fwd;
    logic        int_pending;
    logic        eval;
    logic        unused_bits;

    int_sync #(
        .WIDTH  (6),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d_i (int_raw_i),
        .q_o (int_sync_o)
    );

    // WB-stage CP0 writes are not yet visible in the register block.
    always_comb begin
        status_fwd = status_i;
        cause_fwd  = cause_i;
        epc_fwd    = epc_i;
        if (wb_cp0_we_i) begin
            unique case (wb_cp0_waddr_i)
                CP0_STATUS: status_fwd = wb_cp0_data_i;
                CP0_CAUSE:  cause_fwd  = merge_cause(cause_i, wb_cp0_data_i);
                CP0_EPC:    epc_fwd    = wb_cp0_data_i;
                default:    ;
            endcase
        end
    end

    assign int_pending = (|(cause_fwd[15:8] & status_fwd[15:8])) && !status_fwd[1] &&
                         status_fwd[0];
    assign eval        = (state == StIdle) && !stall_i && (pc_i != 32'd0);

    always_comb begin
        excepttype_o = EXC_NONE;
        if (eval) begin
            if (int_pending)                       excepttype_o = EXC_INT;
            else if (excepttype_i[BIT_SYSCALL])    excepttype_o = EXC_SYSCALL;
            else if (excepttype_i[BIT_INVALID])    excepttype_o = EXC_INVALID;
            else if (excepttype_i[BIT_TRAP])       excepttype_o = EXC_TRAP;
            else if (excepttype_i[BIT_OVERFLOW])   excepttype_o = EXC_OVERFLOW;
            else if (excepttype_i[BIT_ERET])       excepttype_o = EXC_ERET;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= StIdle;
            flush_o       <= 1'b0;
            new_pc_o      <= 32'd0;
            cp0_exc_we_o  <= 1'b0;
            cp0_epc_o     <= 32'd0;
            cp0_exccode_o <= 5'd0;
            cp0_bd_o      <= 1'b0;
            cp0_epc_we_o  <= 1'b0;
            cp0_exl_set_o <= 1'b0;
            cp0_exl_clr_o <= 1'b0;
        end else begin
            flush_o       <= 1'b0;
            cp0_exc_we_o  <= 1'b0;
            cp0_epc_we_o  <= 1'b0;
            cp0_exl_set_o <= 1'b0;
            cp0_exl_clr_o <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (excepttype_o != EXC_NONE) begin
                        state   <= StFlush;
                        flush_o <= 1'b1;
                        if (excepttype_o == EXC_ERET) begin
                            new_pc_o      <= epc_fwd;
                            cp0_exl_clr_o <= 1'b1;
                        end else begin
                            new_pc_o      <= EXC_VECTOR;
                            cp0_exc_we_o  <= 1'b1;
                            cp0_exl_set_o <= 1'b1;
                            cp0_exccode_o <= excepttype_o[4:0];
                            cp0_bd_o      <= is_in_delayslot_i;
                            cp0_epc_o     <= is_in_delayslot_i ? pc_i - 32'd4 : pc_i;
                            // A nested exception must not clobber the outer EPC.
                            cp0_epc_we_o  <= ~status_fwd[1];
                        end
                    end
                end
                StFlush: state <= StDrain;
                StDrain: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    assign busy_o = (state != StIdle);

    assign unused_bits = ^{excepttype_i[31:13], excepttype_i[7:0], cause_fwd[31:16],
                           cause_fwd[7:0], status_fwd[31:16], status_fwd[7:2]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed-vector bench for exc_ctrl: table of single exceptions plus hand-written
// sequences for synchroniser latency, stall hold-off and reset during FLUSH.
module tb_exc_ctrl;

    typedef struct {
        string       name;
        logic [31:0] ex;
        logic [31:0] pc;
        logic        ds;
        logic        stall;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic        wb_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] exp_code;
        logic [31:0] exp_pc;
        logic [31:0] exp_epc;
        logic        exp_bd;
        logic        exp_epc_we;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [5:0]  int_raw_i;
    logic [5:0]  int_sync_o;
    logic        stall_i;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        is_in_delayslot_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        cp0_exc_we_o;
    logic [31:0] cp0_epc_o;
    logic [4:0]  cp0_exccode_o;
    logic        cp0_bd_o;
    logic        cp0_epc_we_o;
    logic        cp0_exl_set_o;
    logic        cp0_exl_clr_o;
    logic        busy_o;

    int n_vec  = 0;
    int n_fail = 0;
    vec_t vecs [$];

    exc_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .int_raw_i         (int_raw_i),
        .int_sync_o        (int_sync_o),
        .stall_i           (stall_i),
        .excepttype_i      (excepttype_i),
        .pc_i              (pc_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .status_i          (status_i),
        .cause_i           (cause_i),
        .epc_i             (epc_i),
        .wb_cp0_we_i       (wb_cp0_we_i),
        .wb_cp0_waddr_i    (wb_cp0_waddr_i),
        .wb_cp0_data_i     (wb_cp0_data_i),
        .excepttype_o      (excepttype_o),
        .flush_o           (flush_o),
        .new_pc_o          (new_pc_o),
        .cp0_exc_we_o      (cp0_exc_we_o),
        .cp0_epc_o         (cp0_epc_o),
        .cp0_exccode_o     (cp0_exccode_o),
        .cp0_bd_o          (cp0_bd_o),
        .cp0_epc_we_o      (cp0_epc_we_o),
        .cp0_exl_set_o     (cp0_exl_set_o),
        .cp0_exl_clr_o     (cp0_exl_clr_o),
        .busy_o            (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] ex, input logic [31:0] pc,
                                input logic ds, input logic stall, input logic [31:0] status,
                                input logic [31:0] cause, input logic [31:0] epc,
                                input logic wb_we, input logic [4:0] waddr,
                                input logic [31:0] wdata, input logic [31:0] exp_code,
                                input logic [31:0] exp_pc, input logic [31:0] exp_epc,
                                input logic exp_bd, input logic exp_epc_we);
        vec_t v;
        v.name = name; v.ex = ex; v.pc = pc; v.ds = ds; v.stall = stall;
        v.status = status; v.cause = cause; v.epc = epc;
        v.wb_we = wb_we; v.waddr = waddr; v.wdata = wdata;
        v.exp_code = exp_code; v.exp_pc = exp_pc; v.exp_epc = exp_epc;
        v.exp_bd = exp_bd; v.exp_epc_we = exp_epc_we;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        excepttype_i      = v.ex;
        pc_i              = v.pc;
        is_in_delayslot_i = v.ds;
        stall_i           = v.stall;
        status_i          = v.status;
        cause_i           = v.cause;
        epc_i             = v.epc;
        wb_cp0_we_i       = v.wb_we;
        wb_cp0_waddr_i    = v.waddr;
        wb_cp0_data_i     = v.wdata;
    endtask

    task automatic idle();
        excepttype_i      = 32'd0;
        pc_i              = 32'd0;
        is_in_delayslot_i = 1'b0;
        stall_i           = 1'b0;
        wb_cp0_we_i       = 1'b0;
        wb_cp0_waddr_i    = 5'd0;
        wb_cp0_data_i     = 32'd0;
    endtask

    task automatic check_strobes_low(input string tag);
        check({tag, ".flush"},   {31'd0, flush_o},       32'd0);
        check({tag, ".exc_we"},  {31'd0, cp0_exc_we_o},  32'd0);
        check({tag, ".epc_we"},  {31'd0, cp0_epc_we_o},  32'd0);
        check({tag, ".exl_set"}, {31'd0, cp0_exl_set_o}, 32'd0);
        check({tag, ".exl_clr"}, {31'd0, cp0_exl_clr_o}, 32'd0);
    endtask

    // Drives one vector at decision cycle T and follows it through FLUSH and DRAIN.
    task automatic apply_vec(input vec_t v);
        logic is_eret;
        is_eret = (v.exp_code == 32'h0000_000e);
        @(negedge clk);
        drive(v);
        #1;
        check({v.name, ".code"}, excepttype_o, v.exp_code);
        @(negedge clk);
        if (v.exp_code != 32'd0) begin
            check({v.name, ".flush"},   {31'd0, flush_o},       32'd1);
            check({v.name, ".busy"},    {31'd0, busy_o},        32'd1);
            check({v.name, ".new_pc"},  new_pc_o,               v.exp_pc);
            check({v.name, ".exc_we"},  {31'd0, cp0_exc_we_o},  {31'd0, !is_eret});
            check({v.name, ".exl_set"}, {31'd0, cp0_exl_set_o}, {31'd0, !is_eret});
            check({v.name, ".exl_clr"}, {31'd0, cp0_exl_clr_o}, {31'd0, is_eret});
            check({v.name, ".epc_we"},  {31'd0, cp0_epc_we_o},  {31'd0, v.exp_epc_we});
            check({v.name, ".flush_code"}, excepttype_o, 32'd0);
            if (!is_eret) begin
                check({v.name, ".epc"},     cp0_epc_o,               v.exp_epc);
                check({v.name, ".exccode"}, {27'd0, cp0_exccode_o},  {27'd0, v.exp_code[4:0]});
                check({v.name, ".bd"},      {31'd0, cp0_bd_o},       {31'd0, v.exp_bd});
            end
            @(negedge clk);
            check({v.name, ".drain_busy"}, {31'd0, busy_o}, 32'd1);
            check({v.name, ".drain_code"}, excepttype_o, 32'd0);
            check_strobes_low({v.name, ".drain"});
            idle();
            @(negedge clk);
            check({v.name, ".idle_busy"}, {31'd0, busy_o}, 32'd0);
        end else begin
            check({v.name, ".noflush"}, {31'd0, flush_o}, 32'd0);
            check({v.name, ".nobusy"},  {31'd0, busy_o},  32'd0);
            idle();
        end
    endtask

    initial begin
        vec_t v;
        rst       = 1'b0;
        int_raw_i = 6'd0;
        status_i  = 32'd0;
        cause_i   = 32'd0;
        epc_i     = 32'd0;
        idle();

        //     name        ex            pc            ds stl status        cause         epc
        //     we waddr data          code          new_pc        epc           bd epc_we
        vecs.push_back(mk("syscall", 32'h100, 32'h100, 0, 0, 32'h1000_0001, 32'h0, 32'h0,
                          0, 5'd0, 32'h0, 32'h8, 32'h20, 32'h100, 0, 1));
        vecs.push_back(mk("ovf_ds", 32'h800, 32'h204, 1, 0, 32'h1000_0001, 32'h0, 32'h0,
                          0, 5'd0, 32'h0, 32'hc, 32'h20, 32'h200, 1, 1));
        vecs.push_back(mk("invalid", 32'h200, 32'h400, 0, 0, 32'h0, 32'h0, 32'h0,
                          0, 5'd0, 32'h0, 32'ha, 32'h20, 32'h400, 0, 1));
        vecs.push_back(mk("trap_nest", 32'h400, 32'h408, 0, 0, 32'h3, 32'h0, 32'h0,
                          0, 5'd0, 32'h0, 32'hd, 32'h20, 32'h408, 0, 0));
        vecs.push_back(mk("sys_ovf", 32'h900, 32'h40c, 0, 0, 32'h1, 32'h0, 32'h0,
                          0, 5'd0, 32'h0, 32'h8, 32'h20, 32'h40c, 0, 1));
        vecs.push_back(mk("inv_trap", 32'h600, 32'h410, 1, 0, 32'h1, 32'h0, 32'h0,
                          0, 5'd0, 32'h0, 32'ha, 32'h20, 32'h40c, 1, 1));
        vecs.push_back(mk("eret_fwd", 32'h1000, 32'h500, 0, 0, 32'h3, 32'h0, 32'h0,
                          1, 5'd14, 32'h340, 32'he, 32'h340, 32'h0, 0, 0));
        vecs.push_back(mk("int_fwd", 32'h0, 32'h504, 0, 0, 32'h0, 32'h400, 32'h0,
                          1, 5'd12, 32'h401, 32'h1, 32'h20, 32'h504, 0, 1));
        vecs.push_back(mk("int_nofwd", 32'h0, 32'h504, 0, 0, 32'h0, 32'h400, 32'h0,
                          0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk("bubble", 32'h100, 32'h0, 0, 0, 32'h1, 32'h0, 32'h0,
                          0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk("int_sys", 32'h100, 32'h600, 0, 0, 32'h401, 32'h400, 32'h0,
                          0, 5'd0, 32'h0, 32'h1, 32'h20, 32'h600, 0, 1));
        vecs.push_back(mk("eret_int", 32'h1000, 32'h604, 0, 0, 32'h3, 32'h400, 32'h0,
                          1, 5'd12, 32'h401, 32'h1, 32'h20, 32'h604, 0, 1));
        vecs.push_back(mk("cause_sw", 32'h0, 32'h608, 0, 0, 32'h301, 32'h0, 32'h0,
                          1, 5'd13, 32'h200, 32'h1, 32'h20, 32'h608, 0, 1));
        vecs.push_back(mk("cause_hw", 32'h0, 32'h60c, 0, 0, 32'h401, 32'h0, 32'h0,
                          1, 5'd13, 32'h400, 32'h0, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk("other_wa", 32'h0, 32'h610, 0, 0, 32'h0, 32'h400, 32'h0,
                          1, 5'd11, 32'h401, 32'h0, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk("ds_wrap", 32'h100, 32'h2, 1, 0, 32'h1, 32'h0, 32'h0,
                          0, 5'd0, 32'h0, 32'h8, 32'h20, 32'hffff_fffe, 1, 1));
        vecs.push_back(mk("stalled", 32'h100, 32'h614, 0, 1, 32'h1, 32'h0, 32'h0,
                          0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.busy", {31'd0, busy_o}, 32'd0);
        check("rst.new_pc", new_pc_o, 32'd0);
        check("rst.epc", cp0_epc_o, 32'd0);
        check("rst.sync", {26'd0, int_sync_o}, 32'd0);
        check_strobes_low("rst");
        rst = 1'b1;

        // Synchroniser latency: SYNC_STAGES cycles
        @(negedge clk);
        int_raw_i = 6'b000001;
        @(negedge clk);
        check("sync.stage1", {26'd0, int_sync_o}, 32'd0);
        @(negedge clk);
        check("sync.stage2", {26'd0, int_sync_o}, 32'd1);
        int_raw_i = 6'b000000;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Stall holds off a trap for 3 cycles, then nested (EXL=1) entry keeps EPC
        for (int pass = 0; pass < 2; pass++) begin
            v = mk("stall_trap", 32'h400, 32'h700, 0, 1, (pass == 0) ? 32'h1 : 32'h3,
                   32'h0, 32'h0, 0, 5'd0, 32'h0, 32'hd, 32'h20, 32'h700, 0, (pass == 0));
            @(negedge clk);
            drive(v);
            for (int c = 0; c < 3; c++) begin
                #1;
                check("stall.code", excepttype_o, 32'd0);
                check("stall.flush", {31'd0, flush_o}, 32'd0);
                @(negedge clk);
            end
            check("stall.flush_end", {31'd0, flush_o}, 32'd0);
            v.stall = 1'b0;
            apply_vec(v);
        end

        // Reset asserted during FLUSH clears everything immediately
        v = vecs[0];
        @(negedge clk);
        drive(v);
        @(negedge clk);
        check("rstflush.flush_pre", {31'd0, flush_o}, 32'd1);
        rst = 1'b0;
        #1;
        check("rstflush.busy", {31'd0, busy_o}, 32'd0);
        check("rstflush.new_pc", new_pc_o, 32'd0);
        check_strobes_low("rstflush");
        idle();
        @(negedge clk);
        rst = 1'b1;
        apply_vec(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt control stage sitting directly downstream of the CP0 register block, alongside the MEM stage.
- Consumes the CP0 status/cause/epc outputs (with WB-stage write forwarding) plus the MEM-stage exception flags, and decides whether an exception or ERET is taken.
- Drives the pipeline flush and new PC, and issues the exception-entry/return update back to CP0.
- Also synchronises the raw external interrupt lines that feed the CP0 cause register.

Parameters:
- EXC_VECTOR, 32'h0000_0020, exception entry PC.
- SYNC_STAGES, 2, flops in the interrupt synchroniser (min 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- int_raw_i  in  6  external interrupt lines, asynchronous.
- int_sync_o  out  6  synchronised interrupts, to CP0 int_i.
- stall_i  in  1  MEM stage held this cycle.
- excepttype_i  in  32  MEM flags: bit8 syscall, bit9 invalid instr, bit10 trap, bit11 overflow, bit12 eret.
- pc_i  in  32  MEM-stage PC; 0 = bubble.
- is_in_delayslot_i  in  1  MEM instruction is in a delay slot.
- status_i / cause_i / epc_i  in  32 each  current CP0 values.
- wb_cp0_we_i  in  1  WB-stage CP0 write enable.
- wb_cp0_waddr_i  in  5  WB-stage CP0 write address.
- wb_cp0_data_i  in  32  WB-stage CP0 write data.
- excepttype_o  out  32  decoded exception code; combinational.
- flush_o  out  1  pipeline flush pulse.
- new_pc_o  out  32  redirect PC, valid when flush_o=1.
- cp0_exc_we_o  out  1  CP0 exception-update strobe.
- cp0_epc_o  out  32  EPC value to write.
- cp0_exccode_o  out  5  Cause.ExcCode value.
- cp0_bd_o  out  1  Cause.BD value.
- cp0_epc_we_o  out  1  write EPC (0 when EXL already set).
- cp0_exl_set_o  out  1  set Status.EXL.
- cp0_exl_clr_o  out  1  clear Status.EXL.
- busy_o  out  1  FSM not IDLE.

Behaviour:
- Reset (rst=0, any time, including mid-FLUSH): FSM to IDLE; all outputs and synchroniser flops cleared to 0.
- Forwarding: fwd values equal the CP0 inputs, except when wb_cp0_we_i=1:
  - waddr 12: status_fwd = data.
  - waddr 13: cause_fwd bits 9:8, 22, 23 come from data; all other bits from cause_i.
  - waddr 14: epc_fwd = data.
- Interrupt condition: |(cause_fwd[15:8] & status_fwd[15:8]), and status_fwd[1]=0, and status_fwd[0]=1.
- Evaluation: only in IDLE, with stall_i=0 and pc_i!=0. Otherwise excepttype_o=0.
- Priority and codes (excepttype_o):
  - interrupt 0x1
  - syscall 0x8
  - invalid 0xa
  - trap 0xd
  - overflow 0xc
  - eret 0xe
  - none 0x0
- FSM: IDLE -> FLUSH -> DRAIN -> IDLE.
  - IDLE -> FLUSH when excepttype_o != 0 (decision cycle T).
  - FLUSH (T+1): flush_o=1 for exactly one cycle; registered outputs valid.
  - DRAIN (T+2): excepttype_i ignored, since the MEM slot holds a flushed bubble.
  - FLUSH and DRAIN ignore stall_i.
  - busy_o=1 in FLUSH and DRAIN.
- Registered outputs for a non-eret exception (valid in FLUSH):
  - new_pc_o = EXC_VECTOR.
  - cp0_exc_we_o=1, cp0_exl_set_o=1.
  - cp0_exccode_o = excepttype_o[4:0].
  - cp0_bd_o = is_in_delayslot_i.
  - cp0_epc_o = pc_i-4 if in delay slot, else pc_i (32-bit wrap allowed).
  - cp0_epc_we_o = ~status_fwd[1]: nested exception keeps the old EPC.
- Registered outputs for eret (valid in FLUSH):
  - new_pc_o = epc_fwd.
  - cp0_exl_clr_o=1; cp0_exc_we_o=0; cp0_epc_we_o=0.
- All strobes are 0 outside FLUSH. new_pc_o holds its last value.
- Simultaneous interrupt and sync exception: interrupt wins; EPC = instruction PC, which re-executes after return.
- ERET with interrupt pending: cannot occur, because EXL=1 masks interrupts. If status is forwarded with EXL=0, the interrupt wins.
- Stall with pending condition: nothing taken; re-evaluated on the first unstalled cycle.
- Synchroniser: SYNC_STAGES-flop chain per bit, reset 0. int_sync_o latency is SYNC_STAGES cycles.

Decomposition:
- Shared package/defines: exception codes (0x1, 0x8, 0xa, 0xc, 0xd, 0xe), CP0 register addresses (STATUS 12, CAUSE 13, EPC 14), MEM flag bit positions, EXC_VECTOR default, FSM state encoding.
- One sub-module: int_sync, a parameterised N-bit multi-flop synchroniser with async active-low reset.

Test Plan:
- Syscall, IDLE: excepttype_i bit8=1, pc_i=0x100, not delay slot, status=0x1000_0001 -> excepttype_o=0x8 at T. At T+1: flush_o=1, new_pc_o=0x20, cp0_epc_o=0x100, cp0_exccode_o=8, cp0_epc_we_o=1, cp0_exl_set_o=1. At T+2: busy_o=1 and excepttype_i is ignored.
- Delay-slot overflow: bit11=1, pc_i=0x204, is_in_delayslot_i=1 -> code 0xc, cp0_epc_o=0x200, cp0_bd_o=1.
- Interrupt via forwarding: int_raw_i=6'b000001 held; cause_i[10] set after sync; status_i IE=0 but WB writes status=0x0000_0401 -> code 0x1, flush at T+1. Same stimulus without the WB write -> no exception.
- ERET: bit12=1, epc_i=0x0, WB writes EPC=0x340 same cycle -> new_pc_o=0x340, cp0_exl_clr_o=1, cp0_exc_we_o=0.
- Stall plus nested exception: trap held with stall_i=1 for 3 cycles -> no flush. Release -> flush on the following cycle. Repeat with status EXL=1 -> cp0_epc_we_o=0.
- Reset mid-FLUSH: drop rst during FLUSH -> flush_o and all strobes 0 immediately; busy_o=0. After release, the next exception completes normally.
